// File: rtl/rst_seq_ctrl.sv
// Staggered per-domain reset release after system reset, plus
// masked soft-reset sequences through a request/acknowledge handshake.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic [NUM_DOMAINS-1:0] SW_RST_MASK,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
  output logic                   SEQ_DONE,
  output logic                   BUSY,
  output logic                   SW_RST_ACK
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(NUM_DOMAINS + 1);

  localparam logic [CW-1:0] HLAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GLAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CONE  = CW'(1);
  localparam logic [IW-1:0] ILAST = IW'(NUM_DOMAINS - 1);
  localparam logic [IW-1:0] IONE  = IW'(1);
  localparam logic [NUM_DOMAINS-1:0] ONE = NUM_DOMAINS'(1);

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    DONE,
    SOFT_HOLD,
    SOFT_RELEASE
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [NUM_DOMAINS-1:0] pend;
  logic [NUM_DOMAINS-1:0] low;
  logic [NUM_DOMAINS-1:0] rest;
  logic [CW-1:0]          limit;

  // lowest still-pending soft domain; unmasked indices cost no gap
  assign low   = pend & (~pend + ONE);
  assign rest  = pend & ~low;
  assign limit = (state == SOFT_HOLD) ? HLAST : GLAST;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= HOLD;
      cnt          <= '0;
      idx          <= '0;
      pend         <= '0;
      DOMAIN_RST_N <= '0;
      SEQ_DONE     <= 1'b0;
      BUSY         <= 1'b1;
      SW_RST_ACK   <= 1'b0;
    end else begin
      SW_RST_ACK <= 1'b0;
      case (state)
        HOLD: begin
          if (cnt == HLAST) begin
            DOMAIN_RST_N <= DOMAIN_RST_N | ONE;
            cnt          <= '0;
            idx          <= IONE;
            if (NUM_DOMAINS == 1) begin
              SEQ_DONE <= 1'b1;
              BUSY     <= 1'b0;
              state    <= DONE;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + CONE;
          end
        end
        RELEASE: begin
          if (cnt == GLAST) begin
            DOMAIN_RST_N <= DOMAIN_RST_N | (ONE << idx);
            cnt          <= '0;
            idx          <= idx + IONE;
            if (idx == ILAST) begin
              SEQ_DONE <= 1'b1;
              BUSY     <= 1'b0;
              state    <= DONE;
            end
          end else begin
            cnt <= cnt + CONE;
          end
        end
        DONE: begin
          if (SW_RST_REQ) begin
            if (|SW_RST_MASK) begin
              DOMAIN_RST_N <= DOMAIN_RST_N & ~SW_RST_MASK;
              BUSY         <= 1'b1;
              cnt          <= '0;
              pend         <= SW_RST_MASK;
              state        <= SOFT_HOLD;
            end else begin
              SW_RST_ACK <= 1'b1;
            end
          end
        end
        SOFT_HOLD, SOFT_RELEASE: begin
          if (cnt == limit) begin
            DOMAIN_RST_N <= DOMAIN_RST_N | low;
            pend         <= rest;
            cnt          <= '0;
            if (rest == '0) begin
              SW_RST_ACK <= 1'b1;
              BUSY       <= 1'b0;
              state      <= DONE;
            end else begin
              state <= SOFT_RELEASE;
            end
          end else begin
            cnt <= cnt + CONE;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: default 3/16/4 instance and a
// single-domain 1/1/1 instance, expectations derived from edge timing.
module tb_rst_seq_ctrl;

  localparam int H = 16;
  localparam int G = 4;

  typedef struct {
    string      name;
    int         t;
    logic [5:0] v;
  } exp_t;

  exp_t sb[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic [2:0] mask = 3'b000;
  logic [2:0] drn;
  logic       done, busy, ack;

  logic       rst1 = 1'b0;
  logic       req1 = 1'b0;
  logic [0:0] mask1 = 1'b0;
  logic [0:0] drn1;
  logic       done1, busy1, ack1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NUM_DOMAINS(3),
    .HOLD_CYCLES(H),
    .GAP_CYCLES(G)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .SW_RST_REQ(req),
    .SW_RST_MASK(mask),
    .DOMAIN_RST_N(drn),
    .SEQ_DONE(done),
    .BUSY(busy),
    .SW_RST_ACK(ack)
  );

  rst_seq_ctrl #(
    .NUM_DOMAINS(1),
    .HOLD_CYCLES(1),
    .GAP_CYCLES(1)
  ) dut1 (
    .CLK(clk),
    .RST(rst1),
    .SW_RST_REQ(req1),
    .SW_RST_MASK(mask1),
    .DOMAIN_RST_N(drn1),
    .SEQ_DONE(done1),
    .BUSY(busy1),
    .SW_RST_ACK(ack1)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [5:0] pon_exp(int e);
    logic [2:0] r;
    logic       d;
    for (int i = 0; i < 3; i++) r[i] = (e >= H + i * G);
    d = (e >= H + 2 * G);
    return {r, d, ~d, 1'b0};
  endfunction

  function automatic logic [5:0] soft_exp(logic [2:0] m, int t);
    logic [2:0] r;
    int         k;
    int         last;
    r = 3'b111;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        r[i] = (t >= H + k * G);
        k++;
      end
    end
    last = H + (k - 1) * G;
    return {r, 1'b1, (t < last), (t == last)};
  endfunction

  function automatic logic [5:0] got3();
    return {drn, done, busy, ack};
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      sb.push_back('{"reset", t, 6'b000_0_1_0});
      tick();
      e = sb.pop_front();
      checks++;
      if (got3() !== e.v) begin
        errors++;
        $display("FAIL %s t=%0d got=%b exp=%b", e.name, e.t, got3(), e.v);
      end
    end
  endtask

  // request at edge 10 arrives mid power-on and must be ignored
  task automatic test_power_on();
    exp_t e;
    rst = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      req  = (n == 10);
      mask = (n == 10) ? 3'b111 : 3'b000;
      sb.push_back('{"power_on", n, pon_exp(n)});
      tick();
      e = sb.pop_front();
      checks++;
      if (got3() !== e.v) begin
        errors++;
        $display("FAIL %s edge=%0d got=%b exp=%b", e.name, e.t, got3(), e.v);
      end
    end
    req  = 1'b0;
    mask = 3'b000;
  endtask

  task automatic test_soft(input logic [2:0] m, input int busy_t,
                           input string name);
    exp_t e;
    int   last;
    last = H + ($countones(m) - 1) * G;
    for (int t = 0; t <= last; t++) begin
      req  = (t == 0) || (t == busy_t);
      mask = (t == 0) ? m : ((t == busy_t) ? 3'b010 : 3'b000);
      sb.push_back('{name, t, soft_exp(m, t)});
      tick();
      e = sb.pop_front();
      checks++;
      if (got3() !== e.v) begin
        errors++;
        $display("FAIL %s t=%0d got=%b exp=%b", e.name, e.t, got3(), e.v);
      end
    end
    req  = 1'b0;
    mask = 3'b000;
  endtask

  task automatic test_zero_mask();
    exp_t e;
    for (int t = -1; t <= 1; t++) begin
      req  = (t == 0);
      mask = 3'b000;
      sb.push_back('{"zero_mask", t, {3'b111, 1'b1, 1'b0, (t == 0)}});
      tick();
      e = sb.pop_front();
      checks++;
      if (got3() !== e.v) begin
        errors++;
        $display("FAIL %s t=%0d got=%b exp=%b", e.name, e.t, got3(), e.v);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int t = 0; t <= 20; t++) begin
      req  = (t == 0);
      mask = (t == 0) ? 3'b111 : 3'b000;
      rst  = (t < 18);
      if (t < 18) sb.push_back('{"reset_mid", t, soft_exp(3'b111, t)});
      else        sb.push_back('{"reset_mid", t, 6'b000_0_1_0});
      tick();
      e = sb.pop_front();
      checks++;
      if (got3() !== e.v) begin
        errors++;
        $display("FAIL %s t=%0d got=%b exp=%b", e.name, e.t, got3(), e.v);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_single();
    exp_t       e;
    logic [5:0] got;
    logic [5:0] seq [5];
    seq[0] = {2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
    seq[1] = {2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
    seq[2] = {2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
    seq[3] = {2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    seq[4] = {2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
    rst1 = 1'b1;
    for (int t = 0; t < 5; t++) begin
      req1  = (t == 2);
      mask1 = (t == 2) ? 1'b1 : 1'b0;
      sb.push_back('{"single", t, seq[t]});
      tick();
      e   = sb.pop_front();
      got = {2'b00, drn1, done1, busy1, ack1};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s t=%0d got=%b exp=%b", e.name, e.t, got, e.v);
      end
    end
    req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_soft(3'b101, 5, "sparse");
    test_soft(3'b010, -1, "back_to_back");
    test_zero_mask();
    test_soft(3'b110, 9, "soft_busy_req");
    test_reset_mid();
    test_power_on();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
